// File: rtl/pipeline_ctrl_if.sv
// rtl/pipeline_ctrl_if.sv - D-stage inputs and hazard/forwarding controls of pipeline_ctrl
interface pipeline_ctrl_if;
  logic [31:0] inst_d;
  logic        valid_d;
  logic        redirect_x;
  logic        mem_busy;
  logic [2:0]  imm_sel;
  logic        stall_f;
  logic        stall_d;
  logic        stall_x;
  logic        flush_d;
  logic        byp_a_d;
  logic        byp_b_d;
  logic        fwd_a_x;
  logic        fwd_b_x;
  logic [31:0] cnt_stall;
  logic [31:0] cnt_flush;

  modport master (
    output inst_d, valid_d, redirect_x, mem_busy,
    input  imm_sel, stall_f, stall_d, stall_x, flush_d,
    input  byp_a_d, byp_b_d, fwd_a_x, fwd_b_x, cnt_stall, cnt_flush
  );

  modport slave (
    input  inst_d, valid_d, redirect_x, mem_busy,
    output imm_sel, stall_f, stall_d, stall_x, flush_d,
    output byp_a_d, byp_b_d, fwd_a_x, fwd_b_x, cnt_stall, cnt_flush
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - hazard, flush and forwarding controller for the 3-stage RV32I core
module pipeline_ctrl (
  input logic             clk,
  input logic             rst,
  pipeline_ctrl_if.slave  bus
);

  logic [6:0] opcode;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] imm_sel_c;
  logic       use_rs1, use_rs2, wr_rd, is_load;
  logic       rs1_live, rs2_live, rd_write, lu;

  logic       x_valid_q, x_valid_d, x_wr_q, x_wr_d, x_load_q, x_load_d;
  logic [4:0] x_rd_q, x_rd_d, w_rd_q, w_rd_d;
  logic       w_valid_q, w_valid_d, w_wr_q, w_wr_d;
  logic       fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
  logic [31:0] cnt_stall_q, cnt_stall_d, cnt_flush_q, cnt_flush_d;
  logic       stall_fd_c, stall_x_c, flush_c;
  logic       unused_inst;

  assign opcode = bus.inst_d[6:0];
  assign rd     = bus.inst_d[11:7];
  assign rs1    = bus.inst_d[19:15];
  assign rs2    = bus.inst_d[24:20];
  assign unused_inst = ^{bus.inst_d[31:25], bus.inst_d[13:12]};

  always_comb begin
    imm_sel_c = 3'd7;
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    wr_rd     = 1'b0;
    is_load   = 1'b0;
    case (opcode)
      7'b0110011: begin use_rs1 = 1'b1; use_rs2 = 1'b1; wr_rd = 1'b1; end
      7'b0010011: begin imm_sel_c = 3'd0; use_rs1 = 1'b1; wr_rd = 1'b1; end
      7'b0000011: begin imm_sel_c = 3'd0; use_rs1 = 1'b1; wr_rd = 1'b1; is_load = 1'b1; end
      7'b0100011: begin imm_sel_c = 3'd1; use_rs1 = 1'b1; use_rs2 = 1'b1; end
      7'b1100011: begin imm_sel_c = 3'd2; use_rs1 = 1'b1; use_rs2 = 1'b1; end
      7'b1100111: begin imm_sel_c = 3'd0; use_rs1 = 1'b1; wr_rd = 1'b1; end
      7'b1101111: begin imm_sel_c = 3'd4; wr_rd = 1'b1; end
      7'b0110111,
      7'b0010111: begin imm_sel_c = 3'd3; wr_rd = 1'b1; end
      // CSR immediate forms (funct3[2]=1) carry a zimm in the rs1 field
      7'b1110011: begin imm_sel_c = 3'd0; use_rs1 = ~bus.inst_d[14]; wr_rd = 1'b1; end
      default: ;
    endcase
  end

  assign rs1_live = bus.valid_d & use_rs1 & (rs1 != 5'd0);
  assign rs2_live = bus.valid_d & use_rs2 & (rs2 != 5'd0);
  assign rd_write = bus.valid_d & wr_rd & (rd != 5'd0);
  assign lu = x_valid_q & x_load_q & x_wr_q &
              ((rs1_live & (rs1 == x_rd_q)) | (rs2_live & (rs2 == x_rd_q)));

  always_comb begin
    x_valid_d   = x_valid_q;
    x_rd_d      = x_rd_q;
    x_wr_d      = x_wr_q;
    x_load_d    = x_load_q;
    w_valid_d   = w_valid_q;
    w_rd_d      = w_rd_q;
    w_wr_d      = w_wr_q;
    fwd_a_d     = fwd_a_q;
    fwd_b_d     = fwd_b_q;
    cnt_stall_d = cnt_stall_q;
    cnt_flush_d = cnt_flush_q;
    stall_fd_c  = 1'b0;
    stall_x_c   = 1'b0;
    flush_c     = 1'b0;
    if (bus.mem_busy) begin
      stall_fd_c = 1'b1;
      stall_x_c  = 1'b1;
    end else begin
      w_valid_d = x_valid_q;
      w_rd_d    = x_rd_q;
      w_wr_d    = x_wr_q;
      if (bus.redirect_x || lu) begin
        // Bubble into X; redirect wins over a load-use on the same cycle
        x_valid_d = 1'b0;
        x_rd_d    = 5'd0;
        x_wr_d    = 1'b0;
        x_load_d  = 1'b0;
        fwd_a_d   = 1'b0;
        fwd_b_d   = 1'b0;
        if (bus.redirect_x) begin
          flush_c     = 1'b1;
          cnt_flush_d = cnt_flush_q + 32'd1;
        end else begin
          stall_fd_c  = 1'b1;
          cnt_stall_d = cnt_stall_q + 32'd1;
        end
      end else begin
        x_valid_d = bus.valid_d;
        x_rd_d    = rd;
        x_wr_d    = rd_write;
        x_load_d  = bus.valid_d & is_load;
        fwd_a_d   = rs1_live & x_valid_q & x_wr_q & (rs1 == x_rd_q);
        fwd_b_d   = rs2_live & x_valid_q & x_wr_q & (rs2 == x_rd_q);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_valid_q   <= 1'b0;
      x_rd_q      <= 5'd0;
      x_wr_q      <= 1'b0;
      x_load_q    <= 1'b0;
      w_valid_q   <= 1'b0;
      w_rd_q      <= 5'd0;
      w_wr_q      <= 1'b0;
      fwd_a_q     <= 1'b0;
      fwd_b_q     <= 1'b0;
      cnt_stall_q <= 32'd0;
      cnt_flush_q <= 32'd0;
    end else begin
      x_valid_q   <= x_valid_d;
      x_rd_q      <= x_rd_d;
      x_wr_q      <= x_wr_d;
      x_load_q    <= x_load_d;
      w_valid_q   <= w_valid_d;
      w_rd_q      <= w_rd_d;
      w_wr_q      <= w_wr_d;
      fwd_a_q     <= fwd_a_d;
      fwd_b_q     <= fwd_b_d;
      cnt_stall_q <= cnt_stall_d;
      cnt_flush_q <= cnt_flush_d;
    end
  end

  assign bus.imm_sel   = imm_sel_c;
  assign bus.stall_f   = stall_fd_c;
  assign bus.stall_d   = stall_fd_c;
  assign bus.stall_x   = stall_x_c;
  assign bus.flush_d   = flush_c;
  assign bus.byp_a_d   = rs1_live & w_valid_q & w_wr_q & (rs1 == w_rd_q);
  assign bus.byp_b_d   = rs2_live & w_valid_q & w_wr_q & (rs2 == w_rd_q);
  assign bus.fwd_a_x   = fwd_a_q;
  assign bus.fwd_b_x   = fwd_b_q;
  assign bus.cnt_stall = cnt_stall_q;
  assign bus.cnt_flush = cnt_flush_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - directed self-checking bench for pipeline_ctrl
module tb_pipeline_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  localparam logic [31:0] LW_X5   = 32'h01022283;
  localparam logic [31:0] ADD_X7  = 32'h006283B3;
  localparam logic [31:0] ADDI_X6 = 32'h42618313;
  localparam logic [31:0] SW_X7   = 32'h0072AC23;

  pipeline_ctrl_if bus ();

  pipeline_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] inst, input logic vld);
    bus.inst_d  = inst;
    bus.valid_d = vld;
  endtask

  task automatic drain();
    drive(32'h0, 1'b0);
    bus.redirect_x = 1'b0;
    bus.mem_busy   = 1'b0;
    cyc();
    cyc();
  endtask

  logic [31:0] dec_inst [6] = '{32'h42618313, 32'h0072AC23, 32'h00428463,
                                32'h1E59E117, 32'h3BF6A26F, 32'h006283B3};
  logic [2:0]  dec_exp  [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd7};

  initial begin
    drive(32'h0, 1'b0);
    bus.redirect_x = 1'b0;
    bus.mem_busy   = 1'b0;
    #2;
    chk("rst_stall_f", bus.stall_f, 0);
    chk("rst_stall_x", bus.stall_x, 0);
    chk("rst_flush_d", bus.flush_d, 0);
    chk("rst_fwd_a", bus.fwd_a_x, 0);
    chk("rst_cnt_stall", bus.cnt_stall, 0);
    chk("rst_cnt_flush", bus.cnt_flush, 0);
    chk("rst_imm_none", bus.imm_sel, 3'd7);

    for (int i = 0; i < 6; i++) begin
      drive(dec_inst[i], 1'b1);
      #1;
      chk($sformatf("imm_sel_%0d", i), bus.imm_sel, dec_exp[i]);
    end

    cyc();
    rst = 1'b0;
    drain();

    // load-use: one stall, add then reads x5 through the regfile bypass
    drive(LW_X5, 1'b1);
    #1 chk("lu_no_stall_on_load", bus.stall_f, 0);
    cyc();
    drive(ADD_X7, 1'b1);
    #1;
    chk("lu_stall_f", bus.stall_f, 1);
    chk("lu_stall_d", bus.stall_d, 1);
    chk("lu_stall_x", bus.stall_x, 0);
    chk("lu_flush_d", bus.flush_d, 0);
    cyc();
    chk("lu_cnt_stall", bus.cnt_stall, 1);
    #1;
    chk("lu_single_stall", bus.stall_f, 0);
    chk("lu_byp_a", bus.byp_a_d, 1);
    cyc();
    chk("lu_fwd_a_after_bubble", bus.fwd_a_x, 0);
    chk("lu_fwd_b", bus.fwd_b_x, 0);
    drain();

    // back-to-back dependency forwards from X into the next X
    drive(ADDI_X6, 1'b1);
    cyc();
    drive(ADD_X7, 1'b1);
    #1 chk("fw_no_stall", bus.stall_f, 0);
    cyc();
    chk("fw_fwd_b", bus.fwd_b_x, 1);
    chk("fw_fwd_a", bus.fwd_a_x, 0);
    drain();

    drive(ADDI_X6, 1'b1);
    cyc();
    drive(SW_X7, 1'b1);
    #1 chk("bp_sw_no_stall", bus.stall_f, 0);
    cyc();
    drive(ADD_X7, 1'b1);
    #1;
    chk("bp_byp_b", bus.byp_b_d, 1);
    chk("bp_byp_a", bus.byp_a_d, 0);
    cyc();
    chk("bp_fwd_b", bus.fwd_b_x, 0);
    drain();

    // redirect beats load-use
    drive(LW_X5, 1'b1);
    cyc();
    drive(ADD_X7, 1'b1);
    bus.redirect_x = 1'b1;
    #1;
    chk("rd_flush_d", bus.flush_d, 1);
    chk("rd_no_stall", bus.stall_f, 0);
    cyc();
    bus.redirect_x = 1'b0;
    drive(32'h0, 1'b0);
    chk("rd_cnt_flush", bus.cnt_flush, 1);
    chk("rd_cnt_stall", bus.cnt_stall, 1);
    chk("rd_fwd_a", bus.fwd_a_x, 0);
    drain();

    drive(LW_X5, 1'b1);
    cyc();
    drive(ADD_X7, 1'b0);
    #1 chk("inv_no_stall", bus.stall_f, 0);
    drain();

    // memory stall freezes everything, then exactly one load-use stall
    drive(LW_X5, 1'b1);
    cyc();
    drive(ADD_X7, 1'b1);
    bus.mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("mb_stall_x_%0d", i), bus.stall_x, 1);
      chk($sformatf("mb_stall_f_%0d", i), bus.stall_f, 1);
      chk($sformatf("mb_flush_%0d", i), bus.flush_d, 0);
      cyc();
      chk($sformatf("mb_cnt_%0d", i), bus.cnt_stall, 1);
    end
    bus.mem_busy = 1'b0;
    #1;
    chk("mb_lu_after", bus.stall_f, 1);
    chk("mb_lu_stall_x", bus.stall_x, 0);
    cyc();
    chk("mb_cnt_after", bus.cnt_stall, 2);
    #1 chk("mb_single_stall", bus.stall_f, 0);
    drain();

    // asynchronous reset in the middle of a load-use stall
    drive(LW_X5, 1'b1);
    cyc();
    drive(ADD_X7, 1'b1);
    #1 chk("ar_pre_stall", bus.stall_f, 1);
    rst = 1'b1;
    #1;
    chk("ar_stall_f", bus.stall_f, 0);
    chk("ar_cnt_stall", bus.cnt_stall, 0);
    chk("ar_cnt_flush", bus.cnt_flush, 0);
    chk("ar_fwd_b", bus.fwd_b_x, 0);
    chk("ar_byp_a", bus.byp_a_d, 0);
    #1 rst = 1'b0;
    #1 chk("ar_post_no_stall", bus.stall_f, 0);
    cyc();
    chk("ar_cnt_stall_after", bus.cnt_stall, 0);
    chk("ar_fwd_a_after", bus.fwd_a_x, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
